// File: rtl/freq_div_ctrl.sv
// Purpose : programmable clock divider (IDLE/RUN/DRAIN) with a valid/ready divisor config port.
// Latency : div_out/tick/cfg_err registered, one cycle after the causing edge; cfg_ready is combinational.
// Backpr. : cfg_ready drops while a divisor is pending in RUN/DRAIN and while rst is high.
//
// Ports:
//   clk_in, rst          clock, synchronous active-high reset
//   run                  level request for divided-clock generation
//   cfg_valid/cfg_ready  divisor handshake; cfg_div sampled on transfer
//   cfg_err              one-cycle pulse after an illegal divisor (<2) was accepted
//   div_out, tick        divided clock and end-of-period pulse
//   busy, cur_div        RUN/DRAIN indicator and divisor in effect
module freq_div_ctrl #(
    parameter logic [3:0] DEFAULT_DIV = 4'd4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       run,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_div,
    output logic       cfg_ready,
    output logic       cfg_err,
    output logic       div_out,
    output logic       tick,
    output logic       busy,
    output logic [3:0] cur_div
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] cur_div_nxt;
    logic       pend, pend_nxt;
    logic [3:0] pend_div, pend_div_nxt;
    logic       div_nxt, tick_nxt, cfg_err_nxt;
    logic       wrap, cfg_xfer, cfg_legal;

    assign wrap      = (state != S_IDLE) && (cnt == cur_div - 4'd1);
    assign cfg_ready = ~rst & ((state == S_IDLE) | ~pend);
    assign cfg_xfer  = cfg_valid & cfg_ready;
    assign cfg_legal = (cfg_div >= 4'd2);
    assign busy      = (state != S_IDLE);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run) state_nxt = S_RUN;
            S_RUN:   if (!run) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (run)       state_nxt = S_RUN;
                else if (wrap) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter, divisor and pending-slot next values
    always_comb begin
        cnt_nxt      = 4'd0;
        cur_div_nxt  = cur_div;
        pend_nxt     = pend;
        pend_div_nxt = pend_div;

        if (state != S_IDLE && state_nxt != S_IDLE && !wrap) begin
            cnt_nxt = cnt + 4'd1;
        end

        if (state == S_IDLE) begin
            // Nothing is running, so a legal divisor applies immediately;
            // when run is also high the first period already uses it.
            if (cfg_xfer && cfg_legal) cur_div_nxt = cfg_div;
        end else begin
            // Divisors only change at a period boundary.
            if (wrap) begin
                pend_nxt = 1'b0;
                if (pend) cur_div_nxt = pend_div;
            end
            if (cfg_xfer && cfg_legal) begin
                if (state_nxt == S_IDLE) begin
                    // Leaving for IDLE: no later wrap exists, apply now so
                    // the pending slot is never left occupied in IDLE.
                    cur_div_nxt = cfg_div;
                end else begin
                    // cfg_ready implies pend was clear, so this cannot clobber
                    // a divisor being applied on this same wrap.
                    pend_nxt     = 1'b1;
                    pend_div_nxt = cfg_div;
                end
            end
        end
    end

    // Output logic: registered outputs are computed from the next state so
    // they line up with the cycle in which that state is current.
    always_comb begin
        div_nxt     = 1'b0;
        tick_nxt    = 1'b0;
        cfg_err_nxt = cfg_xfer & ~cfg_legal;
        if (state_nxt != S_IDLE) begin
            div_nxt  = (cnt_nxt < (cur_div_nxt >> 1));
            tick_nxt = (cnt_nxt == cur_div_nxt - 4'd1);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt      <= 4'd0;
            cur_div  <= DEFAULT_DIV;
            pend     <= 1'b0;
            pend_div <= 4'd0;
            div_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            cur_div  <= cur_div_nxt;
            pend     <= pend_nxt;
            pend_div <= pend_div_nxt;
            div_out  <= div_nxt;
            tick     <= tick_nxt;
            cfg_err  <= cfg_err_nxt;
        end
    end

endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 Parameter DEFAULT_DIV, default 4, meaning: divisor loaded at reset (legal range 2..15).
REQ-002 clk_in  input  1  system clock; all logic on posedge clk_in only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  level; request divided-clock generation.
REQ-005 cfg_valid  input  1  new-divisor request valid.
REQ-006 cfg_div  input  4  requested divisor N.
REQ-007 cfg_ready  output  1  controller can accept a divisor.
REQ-008 cfg_err  output  1  one-cycle pulse; accepted divisor was illegal.
REQ-009 div_out  output  1  divided clock, registered.
REQ-010 tick  output  1  one-cycle pulse on the last cycle of each period, registered.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 cur_div  output  4  divisor currently in effect.

Function
REQ-013 States SHALL be IDLE, RUN and DRAIN; internal period counter cnt SHALL run 0..cur_div-1 and SHALL wrap to 0.
REQ-014 IDLE: cnt=0, div_out=0, tick=0; run=1 -> RUN next cycle.
REQ-015 First RUN cycle: cnt=0, div_out=1.
REQ-016 In RUN/DRAIN: div_out=1 while cnt < (cur_div>>1), else 0. Examples: N=4 -> 2 high/2 low; N=5 -> 2 high/3 low.
REQ-017 tick=1 exactly on cycles with cnt==cur_div-1.
REQ-018 RUN with run=0 -> DRAIN; counting continues unchanged.
REQ-019 DRAIN with run=1 -> RUN; no disturbance to cnt or div_out.
REQ-020 DRAIN at wrap (cnt==cur_div-1) with run=0 -> IDLE; next cycle div_out=0.
REQ-021 Handshake: transfer occurs on a cycle with cfg_valid=1 and cfg_ready=1; cfg_div is sampled on that cycle.
REQ-022 IDLE: cfg_ready=1; legal accepted divisor updates cur_div on the next cycle.
REQ-023 RUN/DRAIN: cfg_ready=~pend, where pend is a one-entry pending register; a legal accepted divisor sets pend and stores pend_div.
REQ-024 Pending divisor application: at a wrap cycle with pend=1, cur_div<=pend_div and pend<=0, so the new period starts with the new divisor.
REQ-025 A divisor never takes effect mid-period.
REQ-026 Acceptance on a wrap cycle with pend=0 SHALL be applied at the following wrap, not the current one.
REQ-027 Entering IDLE from DRAIN with pend=1 SHALL apply pend_div on the same transition.
REQ-028 Illegal divisor (cfg_div<2) SHALL complete the handshake, raise cfg_err for exactly one cycle on the next cycle, and leave cur_div and pend unchanged.
REQ-029 run=1 and cfg transfer in the same IDLE cycle: cur_div updates and RUN starts together; the first period uses the new divisor.
REQ-030 busy=1 iff state is RUN or DRAIN.

Reset
REQ-031 rst=1 SHALL force on the next edge: state=IDLE, cnt=0, pend=0, cur_div=DEFAULT_DIV, div_out=0, tick=0, cfg_err=0.
REQ-032 While rst=1: cfg_ready=0.
REQ-033 Reset SHALL take priority over every other input, including mid-period and with pend=1; the pending divisor is discarded.

Verification
REQ-034 Reset, then run=1 held 12 cycles with DEFAULT_DIV=4 -> div_out 1,1,0,0 repeating; tick on cycles 4, 8, 12; cur_div=4.
REQ-035 In IDLE, cfg_div=5 accepted, then run=1 -> div_out 1,1,0,0,0 repeating; tick every 5 cycles.
REQ-036 Running at N=4, accept cfg_div=3 at cnt=1 -> current period completes 4 cycles; next period is 1,0,0; cfg_ready low until the wrap.
REQ-037 cfg_div=1 offered in RUN -> cfg_err pulse 1 cycle; cur_div and waveform unchanged. cfg_div=0 gives the same response.
REQ-038 run dropped at cnt=0 with N=6 -> 6-cycle period finishes, tick once, then IDLE with busy=0. Repeat, re-raising run during DRAIN -> no gap in waveform.
REQ-039 rst asserted mid-period with pend=1 -> next cycle all outputs at reset values; cur_div=DEFAULT_DIV.
